// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   IF_WE       : write-enable value latched for instruction fetches
//   IF_WDATA_Z  : write-data value latched for instruction fetches
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

  // Fetches never write memory.
  localparam logic IF_WE      = 1'b0;
  localparam logic IF_WDATA_Z = 1'b0;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter
// Up-counter that sticks at all ones instead of wrapping.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears the count
//   en_i  : count enable, one increment per enabled cycle
//   cnt_o : current count (W bits)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}})
      return v;
    else
      return v + W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_o <= '0;
    else if (en_i)
      cnt_o <= sat_inc(cnt_o);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between instruction fetch (IF) and data memory
// (DM). Data requests win over fetches because the MEM-stage instruction is
// older. The pipeline is frozen (stall_o) while any request is outstanding.
// Ports:
//   clk_i, rst_i, start_i          : clock, sync active-high reset, core enable
//   if_req_i/if_addr_i             : fetch request and address
//   if_ack_o/if_data_o             : fetch completion pulse and instruction
//   dm_req_i/dm_we_i/dm_addr_i/
//   dm_wdata_i                     : data request, direction, address, data
//   dm_ack_o/dm_rdata_o            : data completion pulse and read data
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o                    : latched request to the memory port
//   mem_ack_i/mem_rdata_i          : memory completion pulse and read data
//   stall_o                        : combinational pipeline freeze
//   stall_cnt_o                    : saturating count of stalled cycles
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  arb_state_t state_q, state_d;
  logic       d_pend, i_pend;

  // A requester whose ack is pulsing is being released this edge, so its
  // still-high request must not be seen as a fresh one.
  assign d_pend  = dm_req_i & ~dm_ack_o;
  assign i_pend  = if_req_i & ~if_ack_o;
  assign stall_o = d_pend | i_pend;

  assign mem_req_o = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i && d_pend)
          state_d = GNT_D;
        else if (start_i && i_pend)
          state_d = GNT_I;
      end
      GNT_D, GNT_I: begin
        if (mem_ack_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_data_o   <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state_q  <= state_d;
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == GNT_D) begin
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
          end else if (state_d == GNT_I) begin
            mem_we_o    <= IF_WE;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= {DATA_W{IF_WDATA_Z}};
          end
        end
        GNT_D: begin
          if (mem_ack_i) begin
            dm_ack_o <= 1'b1;
            // Writes leave the last read value visible.
            if (!mem_we_o)
              dm_rdata_o <= mem_rdata_i;
          end
        end
        GNT_I: begin
          if (mem_ack_i) begin
            if_ack_o  <= 1'b1;
            if_data_o <= mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Frozen cycles are only counted while the core is running.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_o & start_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and stall controller for the pipelined CPU. The instruction-fetch stage (IF) and the data-memory stage (MEM) share one unified memory port. The block serialises their requests, with data taking priority, and holds the pipeline frozen until each request completes. It sits between the two pipeline stages and the memory model, inside `CPU`, and is gated by the same `start_i` as the rest of the core.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `CNT_W`, default 32: width of the stall-cycle counter.

- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: when low, no new grants are issued; an in-flight access still completes.
- `if_req_i`, in, 1: fetch request; held high until `if_ack_o`.
- `if_addr_i`, in, `ADDR_W`: fetch address; stable while the request is pending.
- `if_ack_o`, out, 1: one-cycle pulse; `if_data_o` is valid in that cycle.
- `if_data_o`, out, `DATA_W`: fetched instruction, registered.
- `dm_req_i`, in, 1: data request; held high until `dm_ack_o`.
- `dm_we_i`, in, 1: 1 = write, 0 = read.
- `dm_addr_i`, in, `ADDR_W`: data address.
- `dm_wdata_i`, in, `DATA_W`: write data.
- `dm_ack_o`, out, 1: one-cycle pulse marking data access complete.
- `dm_rdata_o`, out, `DATA_W`: read data, registered. Unchanged on writes.
- `mem_req_o`, out, 1: memory request; held until `mem_ack_i`.
- `mem_we_o`, out, 1: latched write enable.
- `mem_addr_o`, out, `ADDR_W`: latched address.
- `mem_wdata_o`, out, `DATA_W`: latched write data.
- `mem_ack_i`, in, 1: one-cycle completion pulse from memory; `mem_rdata_i` is valid in that cycle.
- `mem_rdata_i`, in, `DATA_W`: memory read data.
- `stall_o`, out, 1: combinational pipeline freeze.
- `stall_cnt_o`, out, `CNT_W`: saturating count of stalled cycles.

## Operation
- FSM states are IDLE, GNT_D and GNT_I.
- **IDLE.** Requests are masked by their own ack: `d = dm_req_i & ~dm_ack_o`, `i = if_req_i & ~if_ack_o`.
  - If `start_i & d`: go to GNT_D.
  - Else if `start_i & i`: go to GNT_I.
  - On the transition, latch address, we and wdata into the `mem_*` registers. IF always latches we=0 and wdata=0.
  - Data has fixed priority, because the MEM-stage instruction is older.
- **GNT_D / GNT_I.**
  - `mem_req_o` = 1 and the latched fields are held.
  - On `mem_ack_i`: register `mem_rdata_i` into `dm_rdata_o` (reads only) or `if_data_o`. Pulse the matching `*_ack_o` in the next cycle, and return to IDLE in the same edge.
- `mem_ack_i` is ignored in IDLE.
- `stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)`.
- `stall_cnt_o` increments on every cycle in which `stall_o` = 1 and `start_i` = 1. It saturates at all ones.
- Masking by ack prevents a requester from being re-granted in the cycle its ack pulses. The pipeline advances at that edge, so any request present the cycle after is a new one.

## Timing
- **Reset.** State is IDLE. `mem_req_o`, `mem_we_o`, `if_ack_o` and `dm_ack_o` are 0. `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `dm_rdata_o` and `stall_cnt_o` are 0.
- **Reset mid-access.** The access is abandoned and `mem_req_o` is 0 after the reset edge. No ack is issued. A late `mem_ack_i` is ignored.
- **Latency.** Request seen in cycle 0 → `mem_req_o` in cycle 1. Memory acks in cycle k≥1 → `*_ack_o` in cycle k+1. The minimum is 2 cycles.
- **Back-to-back.** With both requests raised in cycle 0, the DM ack pulses in cycle ≥2. The IF grant is taken in the same cycle as the DM ack pulse, so `mem_req_o` for IF is high in the following cycle. There is one IDLE cycle between consecutive accesses.
- `start_i` falling while a grant is active: the access completes and acks normally, and no further grant is issued.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (IDLE, GNT_D, GNT_I).
  - Localparams for the IF write-enable constant (0).
- Sub-module `sat_counter` (parameter `W`; inputs `clk_i`, `rst_i`, `en_i`; output `cnt_o`) implements `stall_cnt_o`.

## Test plan
- **IF read.** Reset, `start_i`=1, IF request to 0x0, memory acks in its first `mem_req_o` cycle with 0x20080005 → `if_ack_o` at cycle 2, `if_data_o`=0x20080005, `stall_cnt_o`=2.
- **Simultaneous requests.** IF to 0x4 and DM read to 0x10, both in cycle 0 → DM is granted first (`mem_addr_o`=0x10), IF second (0x4). One IDLE cycle separates them.
- **DM write.** DM write to 0x8 with data 0xDEADBEEF → `mem_we_o`=1 and `mem_wdata_o`=0xDEADBEEF held through a 3-cycle memory wait. `dm_rdata_o` is unchanged.
- **Reset mid-access.** Assert `rst_i` while in GNT_D, then pulse `mem_ack_i` after reset → no `dm_ack_o`, `mem_req_o`=0, `stall_cnt_o`=0.
- **`start_i` low.** `start_i`=0 with an IF request pending → no `mem_req_o` and `stall_cnt_o` frozen. Raise `start_i` → grant in the next cycle.
- **Saturation.** With `CNT_W`=3 and 10 stalled cycles → `stall_cnt_o`=7.
